// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU port, debug/loader port and data RAM port of the RAM arbiter.
// The dbg_lock signal exists only when RAM_ARB_LOCK_EN is defined.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  dbg_rvalid;
`ifdef RAM_ARB_LOCK_EN
    logic                  dbg_lock;
`endif

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rdata, dbg_rvalid,
`ifdef RAM_ARB_LOCK_EN
        input  dbg_lock,
`endif
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    // Requester / RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rdata, dbg_rvalid,
`ifdef RAM_ARB_LOCK_EN
        output dbg_lock,
`endif
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous-read data RAM between the CPU
// port (fixed priority) and a debug/loader port protected by a starvation counter.
// Optional debug lock mode is compiled in with `define RAM_ARB_LOCK_EN.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_CPU_RD, ARB_DBG_RD} arb_state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t            r_state;
    logic [3:0]            r_starve_cnt;
    logic [3:0]            w_starve_nxt;
    logic                  r_cpu_rvalid;
    logic                  r_dbg_rvalid;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [DATA_WIDTH-1:0] r_last_wdata;
    logic                  w_locked;
    logic                  w_dbg_win;
    logic                  w_cpu_gnt;
    logic                  w_dbg_gnt;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_ram_wdata;

`ifdef RAM_ARB_LOCK_EN
    logic r_locked;

    // Lock is armed by a debug grant with dbg_lock set; it drops as soon as dbg_lock falls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_locked <= 1'b0;
        else     r_locked <= w_dbg_gnt & bus.dbg_lock;
    end

    assign w_locked = r_locked & bus.dbg_lock & bus.dbg_req;
`else
    assign w_locked = 1'b0;
`endif

    // Grants are gated by rst so every grant and the RAM strobe read 0 during reset
    assign w_dbg_win = bus.dbg_req & (~bus.cpu_req | w_locked | (r_starve_cnt == LIMIT));
    assign w_dbg_gnt = ~rst & w_dbg_win;
    assign w_cpu_gnt = ~rst & bus.cpu_req & ~w_dbg_win;

    // Starvation counter: counts CPU wins while debug waits, frozen while locked
    always_comb begin
        w_starve_nxt = '0;
        if (w_locked)
            w_starve_nxt = r_starve_cnt;
        else if (bus.cpu_req && bus.dbg_req && (r_starve_cnt != LIMIT))
            w_starve_nxt = r_starve_cnt + 4'd1;
    end

    // RAM mux: granted port drives the RAM; address/data hold when nobody is granted
    always_comb begin
        w_ram_addr  = r_last_addr;
        w_ram_wdata = r_last_wdata;
        w_ram_we    = 1'b0;
        if (w_cpu_gnt) begin
            w_ram_addr  = bus.cpu_addr;
            w_ram_wdata = bus.cpu_wdata;
            w_ram_we    = bus.cpu_we;
        end else if (w_dbg_gnt) begin
            w_ram_addr  = bus.dbg_addr;
            w_ram_wdata = bus.dbg_wdata;
            w_ram_we    = bus.dbg_we;
        end
    end

    // Arbitration state: read-owner FSM, valid strobes, counter and held RAM fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_starve_cnt <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_last_addr  <= w_ram_addr;
            r_last_wdata <= w_ram_wdata;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            if (w_cpu_gnt && !bus.cpu_we) begin
                r_state      <= ARB_CPU_RD;
                r_cpu_rvalid <= 1'b1;
            end else if (w_dbg_gnt && !bus.dbg_we) begin
                r_state      <= ARB_DBG_RD;
                r_dbg_rvalid <= 1'b1;
            end else begin
                r_state      <= ARB_IDLE;
            end
        end
    end

    // Read data holders keep the last returned value for each port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (r_state == ARB_CPU_RD) r_cpu_rdata <= bus.ram_rdata;
            if (r_state == ARB_DBG_RD) r_dbg_rdata <= bus.ram_rdata;
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.dbg_gnt    = w_dbg_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~w_cpu_gnt;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.cpu_rdata  = (r_state == ARB_CPU_RD) ? bus.ram_rdata : r_cpu_rdata;
    assign bus.dbg_rdata  = (r_state == ARB_DBG_RD) ? bus.ram_rdata : r_dbg_rdata;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_we     = w_ram_we;
    assign bus.ram_wdata  = w_ram_wdata;
endmodule
